// File: rtl/sram_burst_ctrl_if.sv
// User-side request/response and SRAM control signals for sram_burst_ctrl.
// The tristate data pins stay a plain module port.
interface sram_burst_ctrl_if #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 4
);
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  burst_len;
    logic [DATA_W-1:0] wdata;
    logic              wr_ack;
    logic [DATA_W-1:0] rdata;
    logic              rdata_valid;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    modport master (
        output start, rw, addr, burst_len, wdata,
        input  wr_ack, rdata, rdata_valid, busy, done,
        input  sram_addr, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport slave (
        input  start, rw, addr, burst_len, wdata,
        output wr_ack, rdata, rdata_valid, busy, done,
        output sram_addr, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_burst_ctrl.sv
// Async-SRAM burst controller: wait states, address auto-increment, one op in flight.
// Define SRAM_CTRL_TURNAROUND_EN to add a bus TURN cycle after each write operation.
module sram_burst_ctrl #(
    parameter int ADDR_W      = 19,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 0,
    parameter int LEN_W       = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_burst_ctrl_if.slave  bus,
    inout  wire  [DATA_W-1:0] sram_dq
);
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_TURN} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t            state_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic [LEN_W-1:0]  beats_q;
    logic [3:0]        wait_q;
    logic [ADDR_W-1:0] sram_addr_q;
    logic              ce_n_q, oe_n_q, we_n_q;
    logic              dq_oe_q;
    logic [DATA_W-1:0] dq_out_q;
    logic [DATA_W-1:0] rdata_q;
    logic              rdata_valid_q, wr_ack_q, busy_q, done_q;

    // Address wraps modulo 2^ADDR_W with no indication.
    assign addr_d = addr_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            rw_q          <= 1'b0;
            addr_q        <= '0;
            beats_q       <= '0;
            wait_q        <= '0;
            sram_addr_q   <= '0;
            ce_n_q        <= 1'b1;
            oe_n_q        <= 1'b1;
            we_n_q        <= 1'b1;
            dq_oe_q       <= 1'b0;
            dq_out_q      <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            wr_ack_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        rw_q        <= bus.rw;
                        addr_q      <= bus.addr;
                        beats_q     <= bus.burst_len;
                        sram_addr_q <= bus.addr;
                        ce_n_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        wr_ack_q    <= !bus.rw;
                        state_q     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    wr_ack_q <= 1'b0;
                    wait_q   <= WAIT_INIT;
                    oe_n_q   <= !rw_q;
                    we_n_q   <= rw_q;
                    dq_oe_q  <= !rw_q;
                    if (!rw_q) dq_out_q <= bus.wdata;
                    state_q  <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (wait_q != 4'd0) begin
                        wait_q <= wait_q - 4'd1;
                    end else begin
                        oe_n_q <= 1'b1;
                        we_n_q <= 1'b1;
                        if (rw_q) begin
                            rdata_q       <= sram_dq;
                            rdata_valid_q <= 1'b1;
                        end
                        done_q  <= (beats_q == '0);
                        state_q <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    dq_oe_q <= 1'b0;
                    if (beats_q != '0) begin
                        beats_q     <= beats_q - LEN_W'(1);
                        addr_q      <= addr_d;
                        sram_addr_q <= addr_d;
                        wr_ack_q    <= !rw_q;
                        state_q     <= S_SETUP;
                    end else begin
                        ce_n_q <= 1'b1;
`ifdef SRAM_CTRL_TURNAROUND_EN
                        if (!rw_q) begin
                            state_q <= S_TURN;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
`else
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end
                end
                S_TURN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sram_dq         = dq_oe_q ? dq_out_q : {DATA_W{1'bz}};
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_oe_n   = oe_n_q;
    assign bus.sram_we_n   = we_n_q;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rdata_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Scoreboard bench for sram_burst_ctrl with a behavioural async SRAM on the pins.
// Honours SRAM_CTRL_TURNAROUND_EN to expect the extra TURN cycle after writes.
module tb_sram_burst_ctrl;
    localparam int W = 2;
`ifdef SRAM_CTRL_TURNAROUND_EN
    localparam int TURN = 1;
`else
    localparam int TURN = 0;
`endif

    typedef struct {
        logic [18:0] a;
        logic [7:0]  d;
        int          c;
        logic        last;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    wire  [7:0] sram_dq;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t       exp_wr[$];
    exp_t       exp_rd[$];
    logic [7:0] wd_q[$];
    logic [7:0] ref_mem [int];
    logic [7:0] sram [0:(1<<19)-1];

    int busy_run = 0, last_busy = 0, we_run = 0, last_we = 0;
    int wr_ack_cnt = 0, done_cnt = 0, we_cnt = 0;
    logic prev_we_n = 1'b1;

    sram_burst_ctrl_if #(.ADDR_W(19), .DATA_W(8), .LEN_W(4)) bus();

    sram_burst_ctrl #(.ADDR_W(19), .DATA_W(8), .WAIT_CYCLES(W), .LEN_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .sram_dq (sram_dq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign sram_dq = (!bus.sram_ce_n && !bus.sram_oe_n) ? sram[bus.sram_addr] : 8'bz;
    always @(posedge clk)
        if (!bus.sram_ce_n && !bus.sram_we_n) sram[bus.sram_addr] <= sram_dq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Monitor: run lengths, wdata source and scoreboard pops.
    always @(negedge clk) begin
        exp_t e;
        if (bus.busy) busy_run++;
        else begin
            if (busy_run != 0) last_busy = busy_run;
            busy_run = 0;
        end
        if (!bus.sram_we_n) we_run++;
        else begin
            if (we_run != 0) last_we = we_run;
            we_run = 0;
        end
        if (bus.wr_ack) begin
            wr_ack_cnt++;
            bus.wdata = (wd_q.size() != 0) ? wd_q.pop_front() : 8'h00;
        end
        if (!bus.sram_we_n && prev_we_n) begin
            we_cnt++;
            if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                e = exp_wr.pop_front();
                chk("wr_addr", bus.sram_addr, e.a);
                chk("wr_data", sram_dq, e.d);
                chk("wr_cyc", cyc, e.c);
            end
        end
        if (bus.rdata_valid) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                e = exp_rd.pop_front();
                chk("rd_data", bus.rdata, e.d);
                chk("rd_cyc", cyc, e.c);
                chk("rd_done", bus.done, e.last);
            end
        end
        if (bus.done) done_cnt++;
        prev_we_n = bus.sram_we_n;
    end

    task automatic nclk();
        @(negedge clk);
        #1;
    endtask

    task automatic start_op(input bit rd, input logic [18:0] a, input int len,
                            input logic [7:0] d0, input logic [7:0] dstep);
        exp_t e;
        int k;
        nclk();
        k = cyc + 1;
        for (int i = 0; i <= len; i++) begin
            e.a    = a + 19'(i);
            e.last = (i == len);
            if (rd) begin
                e.d = ref_mem.exists(int'(e.a)) ? ref_mem[int'(e.a)] : 8'h00;
                e.c = k + 2 + W + i * (W + 3);
                exp_rd.push_back(e);
            end else begin
                e.d = d0 + 8'(i) * dstep;
                e.c = k + 1 + i * (W + 3);
                ref_mem[int'(e.a)] = e.d;
                wd_q.push_back(e.d);
                exp_wr.push_back(e);
            end
        end
        bus.start = 1'b1;
        bus.rw = rd;
        bus.addr = a;
        bus.burst_len = 4'(len);
        nclk();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 500) begin
            nclk();
            n++;
        end
        if (n >= 500) chk({tag, "_timeout"}, 0, 1);
    endtask

    // After the final HOLD: strobes high, dq released, busy only in TURN.
    task automatic after_op(input string tag, input bit wr, input int busy_exp);
        nclk();
        chk({tag, "_strobes"}, {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 3'b111);
        chk({tag, "_dq_oe"}, dut.dq_oe_q, 1'b0);
        chk({tag, "_busy_post"}, bus.busy, wr ? TURN : 0);
        repeat (2) nclk();
        chk({tag, "_busy_len"}, last_busy, busy_exp);
    endtask

    initial begin
        int d0, a0, w0, n;
        exp_t e;
        bus.start = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.burst_len = '0;
        repeat (3) nclk();
        chk("rst_strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 3'b111);
        chk("rst_dq_oe", dut.dq_oe_q, 1'b0);
        chk("rst_addr", bus.sram_addr, 0);
        chk("rst_rdata", bus.rdata, 0);
        chk("rst_flags", {bus.rdata_valid, bus.wr_ack, bus.busy, bus.done}, 4'b0000);
        rst_n = 1'b1;
        nclk();

        // Single write then single read
        d0 = done_cnt; a0 = wr_ack_cnt;
        start_op(0, 19'h12345, 0, 8'hA5, 8'h00);
        wait_done("wr1", d0);
        after_op("wr1", 1, W + 3 + TURN);
        chk("wr1_we_len", last_we, W + 1);
        chk("wr1_acks", wr_ack_cnt - a0, 1);
        chk("wr1_dones", done_cnt - d0, 1);

        d0 = done_cnt;
        start_op(1, 19'h12345, 0, 8'h00, 8'h00);
        wait_done("rd1", d0);
        after_op("rd1", 0, W + 3);
        chk("rd1_hold", bus.rdata, 8'hA5);

        // Burst write across the top of the address space
        d0 = done_cnt; a0 = wr_ack_cnt;
        start_op(0, 19'h7FFFE, 3, 8'h11, 8'h11);
        wait_done("wrb", d0);
        after_op("wrb", 1, 4 * (W + 3) + TURN);
        chk("wrb_acks", wr_ack_cnt - a0, 4);

        // Burst read back, with a conflicting start while busy
        d0 = done_cnt; w0 = we_cnt;
        start_op(1, 19'h7FFFE, 3, 8'h00, 8'h00);
        nclk();
        bus.start = 1'b1; bus.rw = 1'b0; bus.addr = 19'h00100; bus.burst_len = 4'd5;
        repeat (2) nclk();
        bus.start = 1'b0;
        wait_done("rdb", d0);
        after_op("rdb", 0, 4 * (W + 3));
        chk("rdb_no_write", we_cnt - w0, 0);
        chk("rdb_dones", done_cnt - d0, 1);

        // start held high: back-to-back reads with one IDLE gap
        d0 = done_cnt;
        nclk();
        a0 = cyc + 1;
        for (int j = 0; j < 2; j++) begin
            e.a = 19'h12345; e.d = 8'hA5; e.last = 1'b1;
            e.c = a0 + 2 + W + j * (W + 4);
            exp_rd.push_back(e);
        end
        bus.start = 1'b1; bus.rw = 1'b1; bus.addr = 19'h12345; bus.burst_len = 4'd0;
        n = 0;
        while (done_cnt - d0 < 2 && n < 500) begin
            nclk();
            n++;
        end
        bus.start = 1'b0;
        if (n >= 500) chk("b2b_timeout", 0, 1);
        repeat (3) nclk();
        chk("b2b_dones", done_cnt - d0, 2);

        // Reset during ACCESS of beat 2 of a write burst
        a0 = wr_ack_cnt;
        start_op(0, 19'h00200, 3, 8'h50, 8'h01);
        n = 0;
        while (!(wr_ack_cnt - a0 == 2 && !bus.sram_we_n) && n < 500) begin
            nclk();
            n++;
        end
        if (n >= 500) chk("rstmid_timeout", 0, 1);
        d0 = done_cnt;
        rst_n = 1'b0;
        nclk();
        chk("rstmid_strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 3'b111);
        chk("rstmid_dq_oe", dut.dq_oe_q, 1'b0);
        chk("rstmid_flags", {bus.busy, bus.done, bus.wr_ack}, 3'b000);
        rst_n = 1'b1;
        wd_q.delete();
        exp_wr.delete();
        nclk();
        chk("rstmid_no_done", done_cnt - d0, 0);

        d0 = done_cnt;
        start_op(1, 19'h00200, 0, 8'h00, 8'h00);
        wait_done("rd2", d0);
        after_op("rd2", 0, W + 3);

        chk("sb_rd_empty", exp_rd.size(), 0);
        chk("sb_wr_empty", exp_wr.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
